// File: rtl/sna_pkg.sv
// Shared definitions for the slave-side request adapter: flit field layout,
// flit type codes and the request FSM state encoding.
package sna_pkg;

    localparam int FLIT_W   = 37;

    localparam int TYPE_HI  = 36;
    localparam int TYPE_LO  = 35;
    localparam int WR_BIT   = 34;
    localparam int WSTRB_HI = 33;
    localparam int WSTRB_LO = 30;
    localparam int ADDR_HI  = 29;
    localparam int ADDR_LO  = 0;
    localparam int DATA_HI  = 31;
    localparam int DATA_LO  = 0;
    localparam int SRC_HI   = 34;
    localparam int SRC_LO   = 27;

    typedef enum logic [1:0] {
        FT_INVALID = 2'b00,
        FT_HEADER  = 2'b01,
        FT_BODY    = 2'b10,
        FT_TAIL    = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        S_HDR,
        S_BODY,
        S_TAIL,
        S_ISSUE,
        S_WAIT_RESP
    } state_e;

    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[TYPE_HI:TYPE_LO]);
    endfunction

endpackage

// File: rtl/sna_flit_fifo.sv
// Flit buffer with occupancy look-ahead; a push into a full buffer is dropped
// unless a pop frees a slot in the same cycle.
module sna_flit_fifo
    import sna_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [FLIT_W-1:0] data,
    input  logic              pop,
    output logic [FLIT_W-1:0] head,
    output logic              empty,
    output logic [CNT_W-1:0]  count_next,
    output logic              drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;
    end

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/sna_request.sv
// Slave-side NoC adapter, request path: reassembles header/body/tail flits
// into one AXI4-Lite write or read, with a single transaction outstanding.
module sna_request
    import sna_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int ON_OFF_SLACK = 2,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_valid,
    output logic              on_off,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic              req_done,
    output logic              req_is_write,
    output logic [7:0]        req_src_id,
    input  logic              resp_done,
    output logic              proto_err,
    output logic              ovf_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state;
    state_e            state_next;
    logic [FLIT_W-1:0] head;
    flit_type_e        head_type;
    logic              empty;
    logic [CNT_W-1:0]  count_next;
    logic              drop;
    logic              pop;
    logic              hdr_ld;
    logic              body_ld;
    logic              tail_ld;
    logic              bad_flit;
    logic              issue_done;
    logic              wr_q;

    sna_flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (flit_valid),
        .data       (flit_in),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .count_next (count_next),
        .drop       (drop)
    );

    assign head_type = flit_type(head);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        hdr_ld     = 1'b0;
        body_ld    = 1'b0;
        tail_ld    = 1'b0;
        bad_flit   = 1'b0;
        issue_done = 1'b0;
        case (state)
            S_HDR: if (!empty) begin
                pop = 1'b1;
                if (head_type == FT_HEADER) begin
                    hdr_ld     = 1'b1;
                    state_next = head[WR_BIT] ? S_BODY : S_TAIL;
                end else begin
                    bad_flit = 1'b1;
                end
            end
            S_BODY: if (!empty) begin
                pop = 1'b1;
                if (head_type == FT_BODY) begin
                    body_ld    = 1'b1;
                    state_next = S_TAIL;
                end else begin
                    bad_flit   = 1'b1;
                    state_next = S_HDR;
                end
            end
            S_TAIL: if (!empty) begin
                pop = 1'b1;
                if (head_type == FT_TAIL) begin
                    tail_ld    = 1'b1;
                    state_next = S_ISSUE;
                end else begin
                    bad_flit   = 1'b1;
                    state_next = S_HDR;
                end
            end
            // A write completes once each channel has either handshaken earlier
            // (valid already dropped) or is handshaking now.
            S_ISSUE: begin
                if (wr_q ? ((!awvalid || awready) && (!wvalid || wready))
                         : (arvalid && arready)) begin
                    issue_done = 1'b1;
                    state_next = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: if (resp_done) state_next = S_HDR;
            default: state_next = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_HDR;
            on_off       <= 1'b0;
            awaddr       <= '0;
            awvalid      <= 1'b0;
            wdata        <= '0;
            wstrb        <= '0;
            wvalid       <= 1'b0;
            araddr       <= '0;
            arvalid      <= 1'b0;
            req_done     <= 1'b0;
            req_is_write <= 1'b0;
            req_src_id   <= '0;
            proto_err    <= 1'b0;
            ovf_err      <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state    <= state_next;
            on_off   <= (count_next < CNT_W'(FIFO_DEPTH - ON_OFF_SLACK));
            req_done <= issue_done;
            if (bad_flit)
                proto_err <= 1'b1;
            if (drop)
                ovf_err <= 1'b1;
            if (hdr_ld) begin
                wr_q <= head[WR_BIT];
                if (head[WR_BIT]) begin
                    awaddr <= {head[ADDR_HI:ADDR_LO], 2'b00};
                    wstrb  <= head[WSTRB_HI:WSTRB_LO];
                end else begin
                    araddr <= {head[ADDR_HI:ADDR_LO], 2'b00};
                end
            end
            if (body_ld)
                wdata <= head[DATA_HI:DATA_LO];
            if (awvalid && awready)
                awvalid <= 1'b0;
            if (wvalid && wready)
                wvalid <= 1'b0;
            if (arvalid && arready)
                arvalid <= 1'b0;
            if (tail_ld) begin
                req_src_id <= head[SRC_HI:SRC_LO];
                awvalid    <= wr_q;
                wvalid     <= wr_q;
                arvalid    <= !wr_q;
            end
            if (issue_done)
                req_is_write <= wr_q;
        end
    end

endmodule
